// File: rtl/chip8_keypad_ctrl.sv
// CHIP-8 hex keypad: sync, optional debounce, lowest-key report, FX0A wait.
// Debounce counters are built only when CHIP8_KEYPAD_DEBOUNCE_EN is defined.
module chip8_keypad_ctrl #(
    parameter int NUM_KEYS        = 16,
    parameter int IDX_W           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                key_pressed,
    output logic [IDX_W-1:0]    key_index,
    input  logic                wait_req,
    input  logic                wait_cancel,
    output logic                wait_busy,
    output logic                wait_done,
    output logic [IDX_W-1:0]    wait_key
);

    if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_keys
        $error("NUM_KEYS must be 2..16");
    end
    if ((1 << IDX_W) < NUM_KEYS) begin : g_bad_idx
        $error("IDX_W too narrow for NUM_KEYS");
    end
    if (DEBOUNCE_CYCLES < 1 ||
        (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt
        $error("CNT_W cannot hold DEBOUNCE_CYCLES-1");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE
    } state_t;

    function automatic logic [IDX_W-1:0] lowest(
        input logic [NUM_KEYS-1:0] v
    );
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic bit_at(
        input logic [NUM_KEYS-1:0] v,
        input logic [IDX_W-1:0]    idx
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (idx == IDX_W'(i)) r = v[i];
        end
        return r;
    endfunction

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
        end
    end

`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             stable;

        // Accept a new level only after CNT_MAX+1 differing samples in a row
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync2[g] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2[g];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign key_state[g] = stable;
    end
`else
    assign key_state = sync2;
`endif

    logic [NUM_KEYS-1:0] key_state_q;
    logic [NUM_KEYS-1:0] press_evt;

    assign press_evt = key_state & ~key_state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_state_q <= '0;
            key_pressed <= 1'b0;
            key_index   <= '0;
        end else begin
            key_state_q <= key_state;
            key_pressed <= |key_state;
            key_index   <= lowest(key_state);
        end
    end

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] latch_q;
    logic             latch_load;
    logic             done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        latch_load = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wait_req && !wait_cancel) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (wait_cancel) begin
                    state_d = IDLE;
                end else if (|press_evt) begin
                    state_d    = WAIT_RELEASE;
                    latch_load = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (wait_cancel) begin
                    state_d = IDLE;
                end else if (!bit_at(key_state, latch_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q   <= '0;
            wait_key  <= '0;
            wait_done <= 1'b0;
        end else begin
            wait_done <= done_d;
            if (latch_load) latch_q <= lowest(press_evt);
            if (done_d) wait_key <= latch_q;
        end
    end

endmodule

// File: tb/tb_chip8_keypad_ctrl.sv
// Self-checking bench for chip8_keypad_ctrl (both debounce build options).
`timescale 1ns/1ps
module tb_chip8_keypad_ctrl;

    localparam int NK = 16;
    localparam int IW = 4;
    localparam int DB = 4;
    localparam int CW = 4;
`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys_raw = '0;
    logic [NK-1:0] key_state;
    logic          key_pressed;
    logic [IW-1:0] key_index;
    logic          wait_req = 1'b0;
    logic          wait_cancel = 1'b0;
    logic          wait_busy;
    logic          wait_done;
    logic [IW-1:0] wait_key;

    always #5 clk = ~clk;

    chip8_keypad_ctrl #(
        .NUM_KEYS(NK),
        .IDX_W(IW),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys_raw(keys_raw),
        .key_state(key_state),
        .key_pressed(key_pressed),
        .key_index(key_index),
        .wait_req(wait_req),
        .wait_cancel(wait_cancel),
        .wait_busy(wait_busy),
        .wait_done(wait_done),
        .wait_key(wait_key)
    );

    typedef struct {
        logic [NK-1:0] keys;
        logic [NK-1:0] exp_state;
        logic          exp_pressed;
        logic [IW-1:0] exp_index;
    } vec_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    logic [IW-1:0] done_q[$];
    vec_t          exp_q[$];
    vec_t          vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        wait_req = 1'b1;
        cyc(1);
        wait_req = 1'b0;
    endtask

    task automatic wait_for_done(input int lim, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            cyc(1);
            if (wait_done) got = 1'b1;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    // Completion scoreboard: every wait_done pops the key the bench expected
    always @(negedge clk) begin
        if (!reset && wait_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: wait_key 0x%0h, none expected",
                         wait_key);
            end else begin
                chk("done_wait_key", 32'(wait_key), 32'(done_q.pop_front()));
            end
        end
    end

    initial begin
        vec_t          e;
        logic          seen;
        logic          fell;

        vecs[0] = '{keys: 16'h0420, exp_state: 16'h0420,
                    exp_pressed: 1'b1, exp_index: 4'h5};
        vecs[1] = '{keys: 16'h0400, exp_state: 16'h0400,
                    exp_pressed: 1'b1, exp_index: 4'hA};
        vecs[2] = '{keys: 16'h8000, exp_state: 16'h8000,
                    exp_pressed: 1'b1, exp_index: 4'hF};
        vecs[3] = '{keys: 16'h0001, exp_state: 16'h0001,
                    exp_pressed: 1'b1, exp_index: 4'h0};
        vecs[4] = '{keys: 16'hFFFF, exp_state: 16'hFFFF,
                    exp_pressed: 1'b1, exp_index: 4'h0};
        vecs[5] = '{keys: 16'h0C00, exp_state: 16'h0C00,
                    exp_pressed: 1'b1, exp_index: 4'hA};
        vecs[6] = '{keys: 16'h0000, exp_state: 16'h0000,
                    exp_pressed: 1'b0, exp_index: 4'h0};

        cyc(2);
        chk("rst_key_state", 32'(key_state), 32'd0);
        chk("rst_key_pressed", 32'(key_pressed), 32'd0);
        chk("rst_key_index", 32'(key_index), 32'd0);
        chk("rst_wait_busy", 32'(wait_busy), 32'd0);
        chk("rst_wait_done", 32'(wait_done), 32'd0);
        chk("rst_wait_key", 32'(wait_key), 32'd0);
        reset = 1'b0;
        cyc(2);
        chk("idle_key_state", 32'(key_state), 32'd0);

        // Latency of a single held key
        keys_raw = 16'h0080;
        for (int k = 1; k <= LAT + 1; k++) begin
            cyc(1);
            if (k == LAT - 1) chk("lat_early", 32'(key_state), 32'd0);
            if (k == LAT) begin
                chk("lat_state", 32'(key_state), 32'h0080);
                chk("lat_pressed_lag", 32'(key_pressed), 32'd0);
            end
            if (k == LAT + 1) begin
                chk("lat_pressed", 32'(key_pressed), 32'd1);
                chk("lat_index", 32'(key_index), 32'd7);
            end
        end
        keys_raw = '0;
        cyc(LAT + 2);

`ifdef CHIP8_KEYPAD_DEBOUNCE_EN
        seen = 1'b0;
        keys_raw = 16'h0008;
        for (int k = 0; k < 3 + LAT + 4; k++) begin
            if (k == 3) keys_raw = '0;
            cyc(1);
            seen |= key_state[3];
        end
        chk("glitch_blocked", 32'(seen), 32'd0);
        keys_raw = 16'h0008;
        cyc(10);
        chk("held_10_state", 32'(key_state), 32'h0008);
        keys_raw = '0;
        cyc(LAT + 2);
`else
        keys_raw = 16'h8000;
        cyc(1);
        chk("k15_early", 32'(key_state), 32'd0);
        cyc(1);
        chk("k15_state", 32'(key_state), 32'h8000);
        keys_raw = '0;
        cyc(LAT + 2);
        keys_raw = 16'h0008;
        cyc(1);
        keys_raw = '0;
        chk("glitch_early", 32'(key_state), 32'd0);
        cyc(1);
        chk("glitch_pass", 32'(key_state), 32'h0008);
        cyc(1);
        chk("glitch_gone", 32'(key_state), 32'd0);
        cyc(LAT + 2);
`endif

        // Steady key patterns
        for (int i = 0; i < 7; i++) begin
            keys_raw = vecs[i].keys;
            exp_q.push_back(vecs[i]);
            cyc(LAT + 2);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_state", i), 32'(key_state),
                32'(e.exp_state));
            chk($sformatf("vec%0d_pressed", i), 32'(key_pressed),
                32'(e.exp_pressed));
            chk($sformatf("vec%0d_index", i), 32'(key_index),
                32'(e.exp_index));
        end

        // key_index follows key_state one cycle later on release
        keys_raw = 16'h0420;
        cyc(LAT + 2);
        keys_raw = 16'h0400;
        fell = 1'b0;
        for (int k = 0; k < LAT + 4 && !fell; k++) begin
            cyc(1);
            if (!key_state[5]) fell = 1'b1;
        end
        chk("k5_fell", 32'(fell), 32'd1);
        chk("idx_lag", 32'(key_index), 32'd5);
        cyc(1);
        chk("idx_after", 32'(key_index), 32'hA);
        keys_raw = '0;
        cyc(LAT + 2);

        // Wait with a key already held; press/release key 9
        keys_raw = 16'h0004;
        cyc(LAT + 2);
        pulse_req();
        chk("w1_busy", 32'(wait_busy), 32'd1);
        keys_raw = 16'h0204;
        cyc(LAT + 2);
        chk("w1_busy_held", 32'(wait_busy), 32'd1);
        pulse_req();
        chk("w1_req_ignored", 32'(wait_busy), 32'd1);
        done_q.push_back(4'h9);
        keys_raw = 16'h0004;
        wait_for_done(LAT + 4, "w1_done");
        chk("w1_busy_clr", 32'(wait_busy), 32'd0);
        chk("w1_key", 32'(wait_key), 32'd9);
        wait_req = 1'b1;
        cyc(1);
        wait_req = 1'b0;
        chk("w1_done_1cyc", 32'(wait_done), 32'd0);
        chk("req_in_done_cyc", 32'(wait_busy), 32'd1);
        wait_cancel = 1'b1;
        cyc(1);
        wait_cancel = 1'b0;
        chk("cancel_press", 32'(wait_busy), 32'd0);
        keys_raw = '0;
        cyc(LAT + 2);

        // Cancel during WAIT_RELEASE
        pulse_req();
        keys_raw = 16'h0010;
        cyc(LAT + 2);
        chk("w2_busy", 32'(wait_busy), 32'd1);
        wait_cancel = 1'b1;
        cyc(1);
        wait_cancel = 1'b0;
        chk("w2_cancel_busy", 32'(wait_busy), 32'd0);
        chk("w2_cancel_done", 32'(wait_done), 32'd0);
        keys_raw = '0;
        cyc(LAT + 4);
        chk("w2_key_kept", 32'(wait_key), 32'd9);

        // Request and cancel together
        wait_req = 1'b1;
        wait_cancel = 1'b1;
        cyc(1);
        wait_req = 1'b0;
        wait_cancel = 1'b0;
        chk("req_cancel", 32'(wait_busy), 32'd0);

        // Two keys in the same cycle: lowest latched
        pulse_req();
        keys_raw = 16'h0840;
        cyc(LAT + 2);
        chk("w3_busy", 32'(wait_busy), 32'd1);
        keys_raw = 16'h0040;
        cyc(LAT + 3);
        chk("w3_other_ign", 32'(wait_busy), 32'd1);
        done_q.push_back(4'h6);
        keys_raw = '0;
        wait_for_done(LAT + 4, "w3_done");
        chk("w3_key", 32'(wait_key), 32'd6);
        cyc(2);

        // Reset mid-WAIT_RELEASE
        pulse_req();
        keys_raw = 16'h0010;
        cyc(LAT + 2);
        chk("w4_busy", 32'(wait_busy), 32'd1);
        reset = 1'b1;
        keys_raw = '0;
        #1;
        chk("mrst_key_state", 32'(key_state), 32'd0);
        chk("mrst_key_pressed", 32'(key_pressed), 32'd0);
        chk("mrst_key_index", 32'(key_index), 32'd0);
        chk("mrst_busy", 32'(wait_busy), 32'd0);
        chk("mrst_done", 32'(wait_done), 32'd0);
        chk("mrst_wait_key", 32'(wait_key), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(LAT + 4);
        chk("mrst_idle", 32'(wait_busy), 32'd0);

        chk("pending_done", 32'(done_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_keypad_ctrl.md
# chip8_keypad_ctrl

Parametrised CHIP-8 keypad controller between the raw hex-keypad pins and the CPU core. It synchronises and debounces every key and reports the lowest-indexed pressed key. It also runs the blocking wait-for-key handshake used by the FX0A instruction. A wait completes only on a fresh press followed by release of that same key.

## Interface
- NUM_KEYS, 16, number of keys, 2..16
- IDX_W, 4, key index width, ≥ clog2(NUM_KEYS)
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronised samples needed to accept a level change, ≥1
- CNT_W, 16, debounce counter width, must hold DEBOUNCE_CYCLES-1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- keys_raw  in  NUM_KEYS  raw key levels, 1 = pressed, asynchronous to clk
- key_state  out  NUM_KEYS  debounced key levels
- key_pressed  out  1  at least one debounced key is down
- key_index  out  IDX_W  lowest index with key_state set; 0 when none
- wait_req  in  1  start FX0A wait, single-cycle strobe
- wait_cancel  in  1  abort wait (CPU reset/flush)
- wait_busy  out  1  wait in progress
- wait_done  out  1  one-cycle pulse, wait completed
- wait_key  out  IDX_W  key that completed the wait; held until next completion

## Operation
- Per key, keys_raw passes through a 2-flop synchroniser and then the debounce stage.
- Debounce, per key:
  - Counter clears while the synchronised value equals stable.
  - Counter increments while they differ.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, stable takes the synchronised value and the counter clears.
  - key_state = stable.
- press_evt = key_state & ~key_state_q, where key_state_q is key_state delayed one cycle.
- key_pressed and key_index are registered from key_state with lowest-index priority.
- Wait FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE.
  - IDLE: wait_req → WAIT_PRESS.
  - WAIT_PRESS: a key that is already held does not count. When any press_evt bit is set, latch its lowest index into an internal register and go to WAIT_RELEASE.
  - WAIT_RELEASE: when key_state of the latched key is 0, load wait_key from the latch, pulse wait_done, and go to IDLE. Other keys are ignored.
  - wait_cancel in any state → IDLE; no wait_done; wait_key unchanged.
- wait_busy = state ≠ IDLE.
- Reset values: key_state, key_pressed, key_index, wait_busy, wait_done and wait_key are 0. All synchroniser flops, stable bits and counters are cleared. FSM is IDLE.

## Timing
- With the debounce feature compiled in: a raw change held stable changes key_state DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples it.
- A glitch shorter than DEBOUNCE_CYCLES cycles never reaches key_state.
- key_pressed and key_index lag key_state by 1 cycle.
- press_evt is valid in the same cycle that key_state rises.
- WAIT_PRESS → WAIT_RELEASE on the edge where press_evt ≠ 0.
- wait_done is high for exactly the one cycle after the edge where release is seen. wait_key is valid from that cycle onward.
- Boundary conditions:
  - wait_req while busy: ignored.
  - wait_req and wait_cancel in the same cycle: cancel wins, FSM stays or returns to IDLE.
  - wait_req in the wait_done cycle: accepted (FSM is already IDLE).
  - Several press_evt bits in one cycle: lowest index is latched.
  - Reset mid-wait: immediate return to IDLE; no wait_done.
  - Bits of key_index and wait_key above NUM_KEYS are always 0.

## Configuration
- CHIP8_KEYPAD_DEBOUNCE_EN defined: debounce counters are present and the behaviour above applies.
- Not defined: no counters; key_state = synchroniser output, and raw-to-key_state latency is 2 cycles. DEBOUNCE_CYCLES and CNT_W are ignored. All other behaviour is identical.

## Test plan
- Reset then idle, with DEBOUNCE_CYCLES=4 and macro on → all outputs 0. Raw key 7 held → key_state=0x0080 on cycle 6, then key_pressed=1 and key_index=7 on cycle 7.
- Key 3 pulsed for 3 cycles with DEBOUNCE_CYCLES=4 → key_state stays 0x0000. Key 3 held 10 cycles → bit 3 set.
- Keys 5 and 0xA pressed together → key_index=5. Release key 5 → key_index=0xA one cycle after key_state bit 5 falls.
- Key 2 held, then wait_req, then key 9 pressed and released, key 2 still held → single wait_done pulse with wait_key=9; wait_busy 1→0 in the same cycle.
- wait_req, key 4 pressed, wait_cancel before release → no wait_done, wait_busy=0, wait_key unchanged. Asserting reset mid-WAIT_RELEASE instead → all outputs 0, FSM IDLE.
- Macro undefined: raw key 0xF → key_state bit 15 set 2 cycles after sampling. A 1-cycle glitch passes to key_state.
